// File: rtl/seg7_units_monitor_if.sv
// Bundle between the units-digit display path and its readback monitor.
// Inputs to the monitor: seg_in (active-low {g..a}), carry_in, clr_err.
// Outputs from the monitor: digit/digit_vld/blank, sticky errors, carry_evt/carry_cnt.
interface seg7_units_monitor_if #(
  parameter int CW = 8
);
  logic [6:0]    seg_in;
  logic          carry_in;
  logic          clr_err;
  logic [3:0]    digit;
  logic          digit_vld;
  logic          blank;
  logic          seg_err;
  logic          seq_err;
  logic          carry_err;
  logic          carry_evt;
  logic [CW-1:0] carry_cnt;

  // master: the side that drives the display lines and reads status
  modport master (
    output seg_in, carry_in, clr_err,
    input  digit, digit_vld, blank, seg_err, seq_err, carry_err, carry_evt, carry_cnt
  );

  // slave: the monitor itself
  modport slave (
    input  seg_in, carry_in, clr_err,
    output digit, digit_vld, blank, seg_err, seq_err, carry_err, carry_evt, carry_cnt
  );
endinterface

// File: rtl/seg7_units_monitor.sv
// Purpose: recover the BCD units digit from an async active-low 7-seg bus and check 0..9 order + carry at wrap.
// Latency: seg_in change -> digit_vld is 2+STABLE_CYCLES clk; carry_in rise -> carry_evt is 2 clk.
// Backpressure: none; observe-only, every accepted pattern and carry edge is processed the cycle it occurs.
// Ports: clk, rst_n (async active-low), bus (slave modport: seg_in/carry_in/clr_err in, status out).
module seg7_units_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CW            = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_units_monitor_if.slave  bus
);

  localparam int CNTW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNTW-1:0] MAXC = CNTW'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK_PAT = 7'h7F;

  typedef enum logic [1:0] {EMPTY, TRACK, WRAP} state_t;

  // synchronizers; the seg bus idles at all-off so reset never looks like a digit
  logic [6:0] seg_s1_q, seg_s2_q;
  logic       car_s1_q, car_s2_q, car_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q  <= BLANK_PAT;
      seg_s2_q  <= BLANK_PAT;
      car_s1_q  <= 1'b0;
      car_s2_q  <= 1'b0;
      car_dly_q <= 1'b0;
    end else begin
      seg_s1_q  <= bus.seg_in;
      seg_s2_q  <= seg_s1_q;
      car_s1_q  <= bus.carry_in;
      car_s2_q  <= car_s1_q;
      car_dly_q <= car_s2_q;
    end
  end

  logic carry_evt;
  assign carry_evt = car_s2_q & ~car_dly_q;

  // stability filter: counter saturates at MAXC so "reach" fires once per stable run
  logic [6:0]      cand_q;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            reach;

  always_comb begin
    cnt_d = cnt_q;
    reach = 1'b0;
    if (seg_s2_q != cand_q) begin
      cnt_d = '0;
      reach = (STABLE_CYCLES == 1);
    end else if (cnt_q != MAXC) begin
      cnt_d = cnt_q + CNTW'(1);
      reach = (cnt_d == MAXC);
    end
  end

  // decode active-low pattern
  logic       dec_legal;
  logic [3:0] dec_val;
  always_comb begin
    dec_legal = 1'b1;
    dec_val   = 4'd0;
    case (seg_s2_q)
      7'h40: dec_val = 4'd0;
      7'h79: dec_val = 4'd1;
      7'h24: dec_val = 4'd2;
      7'h30: dec_val = 4'd3;
      7'h19: dec_val = 4'd4;
      7'h12: dec_val = 4'd5;
      7'h02: dec_val = 4'd6;
      7'h78: dec_val = 4'd7;
      7'h00: dec_val = 4'd8;
      7'h10: dec_val = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  state_t        state_q, state_d, eff_state;
  logic [6:0]    acc_pat_q, acc_pat_d;
  logic [3:0]    digit_q, digit_d, nxt_digit;
  logic          vld_q, vld_d, blank_q, blank_d;
  logic          seg_err_q, seg_err_d, seq_err_q, seq_err_d, carry_err_q, carry_err_d;
  logic [CW-1:0] carry_cnt_q, carry_cnt_d;
  logic          accept;

  assign accept    = reach && (seg_s2_q != acc_pat_q);
  assign nxt_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

  always_comb begin
    // a carry edge in the same cycle as a digit resolves WRAP first
    eff_state   = (state_q == WRAP && carry_evt) ? TRACK : state_q;
    state_d     = eff_state;
    acc_pat_d   = acc_pat_q;
    digit_d     = digit_q;
    vld_d       = 1'b0;
    blank_d     = blank_q;
    seg_err_d   = bus.clr_err ? 1'b0 : seg_err_q;
    seq_err_d   = bus.clr_err ? 1'b0 : seq_err_q;
    carry_err_d = bus.clr_err ? 1'b0 : carry_err_q;
    carry_cnt_d = bus.clr_err ? '0 : carry_cnt_q;
    if (carry_evt) carry_cnt_d = carry_cnt_d + CW'(1);

    if (accept) begin
      acc_pat_d = seg_s2_q;
      if (seg_s2_q == BLANK_PAT) begin
        blank_d = 1'b1;
        state_d = EMPTY;
      end else if (!dec_legal) begin
        seg_err_d = 1'b1;
        blank_d   = 1'b0;
        state_d   = EMPTY;
      end else begin
        digit_d = dec_val;
        vld_d   = 1'b1;
        blank_d = 1'b0;
        if (eff_state == EMPTY) begin
          state_d = TRACK;
        end else begin
          if (eff_state == WRAP)    carry_err_d = 1'b1;
          if (dec_val != nxt_digit) seq_err_d   = 1'b1;
          state_d = (digit_q == 4'd9 && dec_val == 4'd0) ? WRAP : TRACK;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q      <= BLANK_PAT;
      cnt_q       <= '0;
      state_q     <= EMPTY;
      acc_pat_q   <= BLANK_PAT;
      digit_q     <= 4'd0;
      vld_q       <= 1'b0;
      blank_q     <= 1'b1;
      seg_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      carry_err_q <= 1'b0;
      carry_cnt_q <= '0;
    end else begin
      cand_q      <= seg_s2_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      acc_pat_q   <= acc_pat_d;
      digit_q     <= digit_d;
      vld_q       <= vld_d;
      blank_q     <= blank_d;
      seg_err_q   <= seg_err_d;
      seq_err_q   <= seq_err_d;
      carry_err_q <= carry_err_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign bus.digit     = digit_q;
  assign bus.digit_vld = vld_q;
  assign bus.blank     = blank_q;
  assign bus.seg_err   = seg_err_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.carry_err = carry_err_q;
  assign bus.carry_evt = carry_evt;
  assign bus.carry_cnt = carry_cnt_q;

endmodule
